// File: rtl/qspi_flash_master_if.sv
// Command/status and flash pin bundle for the fabric-driven flash master.
// Pure wiring, no latency.
// No backpressure: the fabric watches fifo_full/busy/hold before it pushes or starts.
interface qspi_flash_master_if #(
  parameter int G_FIFO_AW = 4
);
  logic [7:0]         p_in_wr_data;
  logic               p_in_wr_en;
  logic               p_in_start;
  logic               p_in_cs_hold;
  logic               p_out_fifo_full;
  logic [G_FIFO_AW:0] p_out_fifo_cnt;
  logic               p_out_ovf;
  logic               p_out_busy;
  logic               p_out_hold;
  logic [7:0]         p_out_rx_data;
  logic               p_out_rx_valid;
  logic               p_out_spi_cs_n;
  logic               p_out_spi_sclk;
  logic               p_out_spi_mosi;
  logic               p_in_spi_miso;

  // Engine side
  modport slave (
    input  p_in_wr_data, p_in_wr_en, p_in_start, p_in_cs_hold, p_in_spi_miso,
    output p_out_fifo_full, p_out_fifo_cnt, p_out_ovf, p_out_busy, p_out_hold,
    output p_out_rx_data, p_out_rx_valid, p_out_spi_cs_n, p_out_spi_sclk, p_out_spi_mosi
  );

  // Fabric sequencer plus flash side
  modport master (
    output p_in_wr_data, p_in_wr_en, p_in_start, p_in_cs_hold, p_in_spi_miso,
    input  p_out_fifo_full, p_out_fifo_cnt, p_out_ovf, p_out_busy, p_out_hold,
    input  p_out_rx_data, p_out_rx_valid, p_out_spi_cs_n, p_out_spi_sclk, p_out_spi_mosi
  );
endinterface

// File: rtl/qspi_flash_master.sv
// SPI mode-0 byte master for the configuration flash, fed by a small TX FIFO.
// CS falls one cycle after start; a byte takes 16*G_CLK_DIV cycles; rx_valid at byte end.
// Pushes into a full FIFO are dropped (sticky ovf); starts are ignored while busy.
module qspi_flash_master #(
  parameter int G_CLK_DIV  = 2,
  parameter int G_FIFO_AW  = 4,
  parameter int G_CS_GUARD = 2
) (
  input  logic               p_in_clk,
  input  logic               p_in_rst_n,
  qspi_flash_master_if.slave bus
);
  localparam int DIV_W = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
  localparam int GRD_W = (G_CS_GUARD > 1) ? $clog2(G_CS_GUARD) : 1;
  localparam int DEPTH = 2 ** G_FIFO_AW;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(G_CLK_DIV - 1);
  localparam logic [GRD_W-1:0]   GRD_LAST = GRD_W'(G_CS_GUARD - 1);
  localparam logic [G_FIFO_AW:0] CNT_FULL = (G_FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_RELEASE, S_GUARD} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [3:0]           edge_q, edge_d;
  logic [GRD_W-1:0]     grd_q, grd_d;
  logic [7:0]           tx_q, tx_d;
  logic [7:0]           rx_sh_q, rx_sh_d;
  logic [7:0]           rx_dat_q, rx_dat_d;
  logic                 rx_vld_q, rx_vld_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 ovf_q, ovf_d;
  logic [G_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [G_FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [G_FIFO_AW:0]   cnt_q, cnt_d;
  logic [7:0]           mem_q [DEPTH];

  logic       fifo_full, push, pop, run, tick, start_ok;
  logic [7:0] pop_dat;

  // FIFO status and half-period tick; full is judged before any same-cycle pop
  always_comb begin
    fifo_full = (cnt_q == CNT_FULL);
    push      = bus.p_in_wr_en & ~fifo_full;
    pop_dat   = mem_q[rd_ptr_q];
    start_ok  = bus.p_in_start & (cnt_q != '0);
    run       = (state_q == S_SETUP) || (state_q == S_SHIFT) ||
                (state_q == S_RELEASE) || (state_q == S_GUARD);
    tick      = run && (div_q == DIV_LAST);
  end

  // Next-state logic for the sequencer, SPI pins, receive path and FIFO pointers
  always_comb begin
    state_d  = state_q;
    div_d    = run ? (tick ? '0 : div_q + 1'b1) : '0;
    edge_d   = edge_q;
    grd_d    = grd_q;
    tx_d     = tx_q;
    rx_sh_d  = rx_sh_q;
    rx_dat_d = rx_dat_q;
    rx_vld_d = 1'b0;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ovf_d    = ovf_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (start_ok) begin
          pop     = 1'b1;
          tx_d    = pop_dat;
          mosi_d  = pop_dat[7];
          cs_n_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_SETUP;
        end else if (state_q == S_HOLD && !bus.p_in_cs_hold) begin
          state_d = S_RELEASE;
        end
      end
      S_SETUP: begin
        if (tick) begin
          edge_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (!edge_q[0]) begin
            // rising edge: the flash bit is captured as SCLK goes high
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], bus.p_in_spi_miso};
            edge_d  = edge_q + 1'b1;
          end else if (edge_q != 4'd15) begin
            sclk_d = 1'b0;
            mosi_d = tx_q[6];
            tx_d   = {tx_q[6:0], 1'b0};
            edge_d = edge_q + 1'b1;
          end else begin
            // byte end: chain the next byte back-to-back if one is queued
            sclk_d   = 1'b0;
            rx_dat_d = rx_sh_q;
            rx_vld_d = 1'b1;
            edge_d   = '0;
            if (cnt_q != '0) begin
              pop    = 1'b1;
              tx_d   = pop_dat;
              mosi_d = pop_dat[7];
            end else if (bus.p_in_cs_hold) begin
              state_d = S_HOLD;
            end else begin
              state_d = S_RELEASE;
            end
          end
        end
      end
      S_RELEASE: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          grd_d   = '0;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        if (tick) begin
          if (grd_q == GRD_LAST) state_d = S_IDLE;
          else                   grd_d   = grd_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.p_in_wr_en && fifo_full) ovf_d = 1'b1;
    wr_ptr_d = wr_ptr_q + G_FIFO_AW'(push);
    rd_ptr_d = rd_ptr_q + G_FIFO_AW'(pop);
    cnt_d    = cnt_q + (G_FIFO_AW + 1)'(push) - (G_FIFO_AW + 1)'(pop);
  end

  // State registers; reset drops any byte in flight
  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      edge_q   <= '0;
      grd_q    <= '0;
      tx_q     <= '0;
      rx_sh_q  <= '0;
      rx_dat_q <= '0;
      rx_vld_q <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      edge_q   <= edge_d;
      grd_q    <= grd_d;
      tx_q     <= tx_d;
      rx_sh_q  <= rx_sh_d;
      rx_dat_q <= rx_dat_d;
      rx_vld_q <= rx_vld_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents are meaningless until written so no reset
  always_ff @(posedge p_in_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.p_in_wr_data;
  end

  assign bus.p_out_fifo_full = fifo_full;
  assign bus.p_out_fifo_cnt  = cnt_q;
  assign bus.p_out_ovf       = ovf_q;
  assign bus.p_out_busy      = run;
  assign bus.p_out_hold      = (state_q == S_HOLD);
  assign bus.p_out_rx_data   = rx_dat_q;
  assign bus.p_out_rx_valid  = rx_vld_q;
  assign bus.p_out_spi_cs_n  = cs_n_q;
  assign bus.p_out_spi_sclk  = sclk_q;
  assign bus.p_out_spi_mosi  = mosi_q;
endmodule

// File: doc/qspi_flash_master.md
Name: qspi_flash_master

Overview:
- Byte-oriented SPI mode-0 master driving the configuration flash: CS, SCLK and MOSI to the flash, MISO back from it.
- Lets the golden image run flash commands (read ID, read status, erase, page program) from fabric logic, e.g. a multiboot/update sequencer.
- Commands are not issued from the external SPI pins.
- Sits between the register-write side of the user SPI slave and the flash pin mux / STARTUPE2 CCLK path.
- A small TX FIFO holds a whole command sequence. CS stays low across consecutive bytes and can be held low between bursts.

Parameters:
- G_CLK_DIV, 2: SCLK half-period in p_in_clk cycles, >=1. SCLK = clk/(2*G_CLK_DIV).
- G_FIFO_AW, 4: TX FIFO address width. Depth = 2**G_FIFO_AW = 16 bytes.
- G_CS_GUARD, 2: minimum CS-high time after release, in half-periods, >=1.

Ports:
- p_in_clk  in  1  Single clock for all logic.
- p_in_rst_n  in  1  Reset. Asynchronous assert, active-low. Deassertion is synchronised externally.
- p_in_wr_data  in  8  TX byte to push.
- p_in_wr_en  in  1  Push p_in_wr_data into the TX FIFO (one-cycle strobe).
- p_in_start  in  1  Begin or resume a transfer (one-cycle strobe).
- p_in_cs_hold  in  1  Level. When 1, CS stays low after the FIFO drains.
- p_out_fifo_full  out  1  TX FIFO full.
- p_out_fifo_cnt  out  G_FIFO_AW+1  TX FIFO occupancy.
- p_out_ovf  out  1  Sticky: a push was dropped.
- p_out_busy  out  1  Engine active, or in CS guard time.
- p_out_hold  out  1  In HOLD state (CS low, idle).
- p_out_rx_data  out  8  Last received byte.
- p_out_rx_valid  out  1  One-cycle pulse when p_out_rx_data updates.
- p_out_spi_cs_n  out  1  Flash chip select, active-low.
- p_out_spi_sclk  out  1  Flash clock.
- p_out_spi_mosi  out  1  Flash data in.
- p_in_spi_miso  in  1  Flash data out. Sampled directly; the path is constrained to one half-period.

Behaviour:
- Reset (async, p_in_rst_n=0), all immediate:
  - cs_n=1, sclk=0, mosi=0.
  - busy=0, hold=0, rx_valid=0, rx_data=0x00, ovf=0.
  - FIFO emptied, cnt=0, FSM in IDLE.
  - Reset mid-transfer truncates the byte; no rx_valid is issued.
- SPI format: mode 0, MSB first, all outputs registered.
  - SCLK idles low.
  - MOSI changes only while SCLK is low (at load and on falling edges).
  - MISO is sampled on each rising edge.
- Half-period tick: counter 0..G_CLK_DIV-1, runs only in SETUP, SHIFT, RELEASE and GUARD. A tick fires when it wraps.
- FIFO:
  - Push is accepted when wr_en=1 and full=0. Full is evaluated before any same-cycle pop.
  - A push when full is dropped and sets ovf. ovf is cleared by an accepted start.
  - Pushes are allowed in every state.
- FSM states: IDLE, SETUP, SHIFT, HOLD, RELEASE, GUARD.
- IDLE:
  - A start with cnt>0 pops byte B, sets cs_n=0, mosi=B[7], busy=1, and goes to SETUP.
  - A start with cnt=0 is ignored and CS stays high.
- SETUP: one tick, then SHIFT.
- SHIFT: 16 ticks per byte, alternating rising and falling SCLK.
  - Rising edge: shift MISO into the rx shifter.
  - Falling edges 1..7: present the next bit on MOSI.
  - 16th tick (SCLK back low): rx_data is loaded and rx_valid pulses in the same cycle.
  - Then, if cnt>0: pop the next byte, set MOSI to its bit7, and continue SHIFT with no gap and no extra half-period.
  - Else, if cs_hold=1: go to HOLD.
  - Else: go to RELEASE.
- HOLD:
  - cs_n=0, sclk=0, busy=0, hold=1.
  - A start with cnt>0 pops, goes to SETUP, and CS never rises.
  - cs_hold=0 goes to RELEASE.
- RELEASE: one tick with CS low, then cs_n=1 and go to GUARD.
- GUARD: G_CS_GUARD ticks with busy=1, then IDLE, busy=0.
- Start while busy=1 is ignored. In HOLD, busy=0, so start is honoured there.
- cs_hold is sampled only at byte end and while in HOLD. Changing it mid-byte has no effect until then.
- Timing with no hold, n bytes: cs_n is low for (2+16n)*G_CLK_DIV cycles. cs_n falls the cycle after the start strobe.

Test Plan:
- Read ID, G_CLK_DIV=2:
  - Stimulus: push 0x9F,0x00,0x00,0x00; start; model returns 0xEF,0x40,0x18 on bytes 2..4.
  - Required: MOSI stream 9F 00 00 00; 4 rx_valid pulses, rx_data = FF*,EF,40,18 (byte 1 = MISO idle-high); cs_n low for 132 cycles; SCLK period 4 cycles; 32 SCLK rising edges total.
- Hold across bursts:
  - Stimulus: cs_hold=1; push 0x05; start; after the byte, wait 50 cycles; push 0x00; start; then drop cs_hold.
  - Required: cs_n stays 0 throughout; hold=1 during the gap; second rx_valid returns the status byte; then one RELEASE half-period, cs_n=1, busy=1 for G_CS_GUARD*G_CLK_DIV=4 cycles.
- Overflow:
  - Stimulus: push 17 bytes 0x00..0x10 in IDLE.
  - Required: cnt=16, full=1, ovf=1; byte 0x10 is never transmitted; the next accepted start clears ovf.
- Ignored starts:
  - Stimulus: start with an empty FIFO; start during SHIFT; start during GUARD.
  - Required: no CS activity from the first; bitstream and timing unchanged by the other two.
- Push during shift:
  - Stimulus: push 0xA5; start; push 0x3C at SCLK edge 5.
  - Required: continuous 16-edge SCLK with no gap; MOSI = A5 then 3C.
- Reset mid-byte:
  - Stimulus: assert p_in_rst_n=0 after 3 SCLK rising edges.
  - Required: cs_n=1, sclk=0, mosi=0, cnt=0 immediately (asynchronous); no rx_valid.
